// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the memory slave's state type and its transfer
// legality check.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Only aligned, word-sized accesses inside the local memory are legal.
    function automatic logic xferError(input logic [31:0] addr,
                                       input logic [2:0]  size,
                                       input int unsigned depth);
        return (addr >= (depth << 2)) || (size != HSIZE_WORD) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word memory with one write port and one registered read port; the whole
// array and the read register clear asynchronously.
module ahb_slave_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wrEn_i,
    input  logic [AW-1:0] wrAddr_i,
    input  logic [31:0]   wrData_i,
    input  logic          rdEn_i,
    input  logic          rdClr_i,
    input  logic [AW-1:0] rdAddr_i,
    output logic [31:0]   rdData_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdData_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // A write landing on the word being read in the same cycle is forwarded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdData_q <= '0;
        end else if (rdClr_i) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= (wrEn_i && (wrAddr_i == rdAddr_i)) ? wrData_i : mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: fixed wait states on legal transfers, two-cycle
// ERROR response on illegal ones, registered read data.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    slave_state_e  state_q, state_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic [AW-1:0] addrIdx_q, addrIdx_d;
    logic          write_q, write_d;

    logic          accept;
    logic          reqError;
    logic [AW-1:0] reqIdx;
    logic          ramWrEn;
    logic          ramRdEn;
    logic          ramRdClr;
    logic [AW-1:0] ramRdAddr;

    assign reqIdx   = haddr[AW+1:2];
    assign reqError = xferError(haddr, hsize, DEPTH);
    assign ramWrEn  = (state_q == ST_DATA) && write_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            addrIdx_q <= '0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            addrIdx_q <= addrIdx_d;
            write_q   <= write_d;
        end
    end

    // A new address phase is only taken while the slave is driving hreadyout high.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        addrIdx_d = addrIdx_q;
        write_d   = write_q;
        accept    = 1'b0;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        ramRdEn   = 1'b0;
        ramRdClr  = 1'b0;
        ramRdAddr = reqIdx;

        case (state_q)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (waitCnt_q == 4'd0) begin
                    state_d   = ST_DATA;
                    ramRdEn   = !write_q;
                    ramRdAddr = addrIdx_q;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                hresp   = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                accept  = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
                state_d = ST_IDLE;
                if (accept) begin
                    addrIdx_d = reqIdx;
                    write_d   = hwrite;
                    if (reqError) begin
                        state_d  = ST_ERR1;
                        ramRdClr = !hwrite;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d   = ST_WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                        ramRdEn = !hwrite;
                    end
                end
            end
        endcase
    end

    ahb_slave_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i    (hclk),
        .rst_n_i  (hresetn),
        .wrEn_i   (ramWrEn),
        .wrAddr_i (addrIdx_q),
        .wrData_i (hwdata),
        .rdEn_i   (ramRdEn),
        .rdClr_i  (ramRdClr),
        .rdAddr_i (ramRdAddr),
        .rdData_o (hrdata)
    );

endmodule
